// File: rtl/qadd_accum_sat.sv
// qadd_accum_sat
//   Multi-lane signed fixed-point add / subtract / accumulate / load unit
//   with per-lane saturation, sticky clamp flags and a saturating clamp-event
//   counter. One-entry registered output stage with valid/ready handshake.
//
// Parameters
//   I   integer bits per sample (sign included)
//   F   fractional bits per sample; sample width W = I+F
//   CH  number of independent lanes
//   CW  width of the clamp-event counter
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   valid_i       input beat valid
//   ready_o       block can accept an input beat
//   mode_i        00 add, 01 subtract, 10 accumulate, 11 load
//   a_i, b_i      packed signed operands, lane k = [k*W +: W]
//   clr_sat_i     clear sticky flags and event counter
//   valid_o       output beat valid
//   ready_i       downstream accepts the output beat
//   result_o      packed signed saturated results
//   sat_o         per-lane: current result_o was clamped
//   sat_sticky_o  per-lane: a clamp occurred since the last clear
//   sat_cnt_o     accepted beats with at least one clamped lane (saturating)
module qadd_accum_sat #(
  parameter int I  = 4,
  parameter int F  = 4,
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            mode_i,
  input  logic [CH*(I+F)-1:0]   a_i,
  input  logic [CH*(I+F)-1:0]   b_i,
  input  logic                  clr_sat_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CH*(I+F)-1:0]   result_o,
  output logic [CH-1:0]         sat_o,
  output logic [CH-1:0]         sat_sticky_o,
  output logic [CW-1:0]         sat_cnt_o
);

  localparam int W = I + F;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;

  // Representable range expressed in the W+1-bit intermediate width.
  localparam logic signed [W:0]   MAX_EXT = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   MIN_EXT = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  function automatic logic is_clamped(input logic signed [W:0] x);
    return (x > MAX_EXT) || (x < MIN_EXT);
  endfunction

  function automatic logic signed [W-1:0] sat_val(input logic signed [W:0] x);
    if (x > MAX_EXT)
      return MAX_VAL;
    else if (x < MIN_EXT)
      return MIN_VAL;
    else
      return x[W-1:0];
  endfunction

  logic                  vld_p1;
  logic [CH*W-1:0]       res_p1;
  logic [CH-1:0]         sat_p1;
  logic signed [W-1:0]   acc_r [CH];
  logic [CH-1:0]         sticky_r;
  logic [CW-1:0]         cnt_r;

  logic                  accept;
  logic [CH*W-1:0]       res_c;
  logic [CH-1:0]         sat_c;
  logic signed [W:0]     a_ext [CH];
  logic signed [W:0]     b_ext [CH];
  logic signed [W:0]     acc_ext [CH];
  logic signed [W:0]     sum_c [CH];

  // The output register either is empty or is being drained this cycle.
  assign ready_o = !vld_p1 || ready_i;
  assign accept  = valid_i && ready_o;

  // Stage p0 -> p1: per-lane arithmetic in W+1 bits, then clamp to W bits.
  always_comb begin
    res_c = '0;
    sat_c = '0;
    for (int k = 0; k < CH; k++) begin
      a_ext[k]   = {a_i[k*W + W - 1], a_i[k*W +: W]};
      b_ext[k]   = {b_i[k*W + W - 1], b_i[k*W +: W]};
      acc_ext[k] = {acc_r[k][W-1], acc_r[k]};
      case (mode_i)
        MODE_ADD: sum_c[k] = a_ext[k] + b_ext[k];
        MODE_SUB: sum_c[k] = a_ext[k] - b_ext[k];
        MODE_ACC: sum_c[k] = acc_ext[k] + a_ext[k];
        default:  sum_c[k] = a_ext[k];   // load: always in range, never clamps
      endcase
      res_c[k*W +: W] = sat_val(sum_c[k]);
      sat_c[k]        = is_clamped(sum_c[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      sat_p1   <= '0;
      sticky_r <= '0;
      cnt_r    <= '0;
      for (int k = 0; k < CH; k++)
        acc_r[k] <= '0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        res_p1 <= res_c;
        sat_p1 <= sat_c;
        // Accumulate and load both leave the lane result in the accumulator.
        if (mode_i[1]) begin
          for (int k = 0; k < CH; k++)
            acc_r[k] <= res_c[k*W +: W];
        end
      end else if (ready_i) begin
        vld_p1 <= 1'b0;
      end

      // A clamp on a beat accepted in the clearing cycle survives the clear.
      if (clr_sat_i) begin
        sticky_r <= accept ? sat_c : '0;
        cnt_r    <= (accept && (|sat_c)) ? CW'(1) : '0;
      end else if (accept && (|sat_c)) begin
        sticky_r <= sticky_r | sat_c;
        if (!(&cnt_r))
          cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign valid_o      = vld_p1;
  assign result_o     = res_p1;
  assign sat_o        = sat_p1;
  assign sat_sticky_o = sticky_r;
  assign sat_cnt_o    = cnt_r;

endmodule

// File: tb/tb_qadd_accum_sat.sv
module tb_qadd_accum_sat;
  localparam int I    = 4;
  localparam int F    = 4;
  localparam int W    = I + F;
  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int MAXV = 127;
  localparam int MINV = -128;
  localparam int CMAX = 65535;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      mode_i;
  logic [CH*W-1:0] a_i;
  logic [CH*W-1:0] b_i;
  logic            clr_sat_i;
  logic            valid_o;
  logic            ready_i;
  logic [CH*W-1:0] result_o;
  logic [CH-1:0]   sat_o;
  logic [CH-1:0]   sat_sticky_o;
  logic [CW-1:0]   sat_cnt_o;

  always #5 clk = ~clk;

  qadd_accum_sat #(.I(I), .F(F), .CH(CH), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .clr_sat_i(clr_sat_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .sat_o(sat_o), .sat_sticky_o(sat_sticky_o), .sat_cnt_o(sat_cnt_o)
  );

  typedef struct {
    logic [CH*W-1:0] res;
    logic [CH-1:0]   sat;
  } exp_t;

  exp_t expq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            mvalid;
  int            acc [CH];
  logic [CH-1:0] msticky;
  int            mcnt;
  bit            mon_en = 1'b0;

  // Inputs currently applied to the DUT.
  bit              cur_v, cur_r, cur_c, cur_rs;
  logic [1:0]      cur_m;
  logic [CH*W-1:0] cur_a, cur_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [CH*W-1:0] pk(input logic [W-1:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  // Advance the model by one clock edge using the applied inputs.
  task automatic model_edge();
    bit            acc_ok;
    logic [CH-1:0] satv;
    int            r;
    logic [31:0]   rv;
    exp_t          e;
    if (cur_rs) begin
      mvalid  = 1'b0;
      for (int k = 0; k < CH; k++) acc[k] = 0;
      msticky = '0;
      mcnt    = 0;
      expq.delete();
    end else begin
      acc_ok = cur_v && (!mvalid || cur_r);
      satv   = '0;
      if (acc_ok) begin
        e.res = '0;
        for (int k = 0; k < CH; k++) begin
          case (cur_m)
            2'd0:    r = sx(cur_a[k*W +: W]) + sx(cur_b[k*W +: W]);
            2'd1:    r = sx(cur_a[k*W +: W]) - sx(cur_b[k*W +: W]);
            2'd2:    r = acc[k] + sx(cur_a[k*W +: W]);
            default: r = sx(cur_a[k*W +: W]);
          endcase
          if (r > MAXV) begin r = MAXV; satv[k] = 1'b1; end
          else if (r < MINV) begin r = MINV; satv[k] = 1'b1; end
          if (cur_m == 2'd2 || cur_m == 2'd3) acc[k] = r;
          rv = r;
          e.res[k*W +: W] = rv[W-1:0];
        end
        e.sat = satv;
        expq.push_back(e);
      end
      if (cur_c) begin
        msticky = satv;
        mcnt    = (satv != 0) ? 1 : 0;
      end else begin
        msticky = msticky | satv;
        if (satv != 0 && mcnt < CMAX) mcnt++;
      end
      mvalid = acc_ok || (mvalid && !cur_r);
    end
  endtask

  // One clock cycle: apply inputs, check ready, clock, update model, check state.
  task automatic cyc(input bit v, input logic [1:0] m, input logic [CH*W-1:0] a,
                     input logic [CH*W-1:0] b, input bit r, input bit c, input bit rs);
    cur_v = v; cur_m = m; cur_a = a; cur_b = b; cur_r = r; cur_c = c; cur_rs = rs;
    valid_i = v; mode_i = m; a_i = a; b_i = b; ready_i = r; clr_sat_i = c; rst_i = rs;
    #1;
    chk("ready_o", 64'(ready_o), 64'(!mvalid || r));
    @(posedge clk);
    #1;
    model_edge();
    chk("valid_o", 64'(valid_o), 64'(mvalid));
    chk("sat_sticky_o", 64'(sat_sticky_o), 64'(msticky));
    chk("sat_cnt_o", 64'(sat_cnt_o), 64'(mcnt));
  endtask

  // Monitor: the head of the scoreboard must be on the outputs whenever
  // valid_o is high; it is retired when downstream takes it.
  always @(negedge clk) begin
    if (mon_en && valid_o === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 64'(valid_o), 64'(0));
      end else begin
        chk("result_o", 64'(result_o), 64'(expq[0].res));
        chk("sat_o", 64'(sat_o), 64'(expq[0].sat));
        if (ready_i === 1'b1) void'(expq.pop_front());
      end
    end
  end

  localparam logic [CH*W-1:0] Z = '0;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; mode_i = 2'd0; a_i = '0; b_i = '0;
    ready_i = 1'b1; clr_sat_i = 1'b0;
    cur_rs = 1'b1; cur_v = 1'b0; cur_r = 1'b1; cur_c = 1'b0; cur_m = 2'd0; cur_a = '0; cur_b = '0;
    repeat (2) @(posedge clk);
    #1;
    model_edge();
    mon_en = 1'b1;

    // Reset state.
    chk("rst_valid_o", 64'(valid_o), 64'(0));
    chk("rst_result_o", 64'(result_o), 64'(0));
    chk("rst_sat_o", 64'(sat_o), 64'(0));
    chk("rst_sticky", 64'(sat_sticky_o), 64'(0));
    chk("rst_cnt", 64'(sat_cnt_o), 64'(0));
    chk("rst_ready_o", 64'(ready_o), 64'(1));

    // Add with clamp in lane 0 only.
    cyc(1, 2'd0, pk(8'h00, 8'h00, 8'h10, 8'h64), pk(8'h00, 8'h00, 8'h20, 8'h32), 1, 0, 0);
    chk("add_lane0", 64'(result_o[7:0]), 64'h7F);
    chk("add_lane1", 64'(result_o[15:8]), 64'h30);
    chk("add_sat", 64'(sat_o), 64'b0001);
    chk("add_cnt", 64'(sat_cnt_o), 64'd1);

    // Subtract clamping both ways, including 0 - min.
    cyc(1, 2'd1, pk(8'h00, 8'h00, 8'h00, 8'h80), pk(8'h00, 8'h00, 8'h80, 8'h01), 1, 0, 0);
    chk("sub_res", 64'(result_o[15:0]), 64'h7F80);
    chk("sub_sat", 64'(sat_o[1:0]), 64'b11);
    chk("sub_sticky", 64'(sat_sticky_o[1:0]), 64'b11);

    // Load then accumulate to saturation and back down.
    cyc(1, 2'd3, Z, pk(8'h55, 8'h55, 8'h55, 8'h55), 1, 0, 0);
    chk("load_sat", 64'(sat_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'd2, pk(8'h3C, 8'h3C, 8'h3C, 8'h3C), Z, 1, 0, 0);
      chk("acc_step", 64'(result_o[7:0]), (i == 0) ? 64'h3C : (i == 1) ? 64'h78 : 64'h7F);
    end
    chk("acc_sat", 64'(sat_o), 64'hF);
    cyc(1, 2'd2, pk(8'hC4, 8'hC4, 8'hC4, 8'hC4), Z, 1, 0, 0);
    chk("acc_down", 64'(result_o[7:0]), 64'h43);

    // Back-pressure: hold the output for 3 cycles with a new beat pending.
    cyc(1, 2'd0, pk(8'h01, 8'h02, 8'h03, 8'h04), Z, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'd0, pk(8'h11, 8'h12, 8'h13, 8'h14), Z, 0, 0, 0);
      chk("stall_hold", 64'(result_o), 64'(pk(8'h01, 8'h02, 8'h03, 8'h04)));
    end
    cyc(1, 2'd0, pk(8'h11, 8'h12, 8'h13, 8'h14), Z, 1, 0, 0);
    chk("stall_next", 64'(result_o), 64'(pk(8'h11, 8'h12, 8'h13, 8'h14)));
    cyc(0, 2'd0, Z, Z, 1, 0, 0);
    chk("drain_valid", 64'(valid_o), 64'd0);

    // Clear alone, then clear together with a clamping beat.
    cyc(0, 2'd0, Z, Z, 1, 1, 0);
    chk("clr_sticky", 64'(sat_sticky_o), 64'd0);
    chk("clr_cnt", 64'(sat_cnt_o), 64'd0);
    cyc(1, 2'd0, pk(8'h00, 8'h00, 8'h00, 8'h7F), pk(8'h00, 8'h00, 8'h00, 8'h7F), 1, 1, 0);
    chk("clr_win_sticky", 64'(sat_sticky_o), 64'b0001);
    chk("clr_win_cnt", 64'(sat_cnt_o), 64'd1);

    // Reset in the middle of an accumulate stream.
    cyc(1, 2'd2, pk(8'h07, 8'h07, 8'h07, 8'h07), Z, 1, 0, 0);
    cyc(1, 2'd2, pk(8'h07, 8'h07, 8'h07, 8'h07), Z, 1, 1, 1);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_result", 64'(result_o), 64'd0);
    chk("mid_rst_sticky", 64'(sat_sticky_o), 64'd0);
    cyc(1, 2'd2, pk(8'h05, 8'h05, 8'h05, 8'h05), Z, 1, 0, 0);
    chk("post_rst_acc", 64'(result_o), 64'(pk(8'h05, 8'h05, 8'h05, 8'h05)));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), CH*W'($urandom), CH*W'($urandom),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    // Fill the event counter past its ceiling.
    cyc(0, 2'd0, Z, Z, 1, 1, 0);
    for (int i = 0; i < 65536; i++)
      cyc(1, 2'd0, pk(8'h7F, 8'h7F, 8'h7F, 8'h7F), pk(8'h7F, 8'h7F, 8'h7F, 8'h7F), 1, 0, 0);
    chk("cnt_hold", 64'(sat_cnt_o), 64'hFFFF);

    repeat (4) cyc(0, 2'd0, Z, Z, 1, 0, 0);
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qadd_accum_sat.md
QADD_ACCUM_SAT -- requirements
Module: qadd_accum_sat

Interface
REQ-001 Parameter I, default 4: integer bits per fixed-point sample, sign included.
REQ-002 Parameter F, default 4: fractional bits per sample; W = I+F.
REQ-003 Parameter CH, default 4: number of independent lanes.
REQ-004 Parameter CW, default 16: width of the saturation-event counter.
REQ-005 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 valid_i  in  1  input beat valid.
REQ-008 ready_o  out  1  block can accept an input beat.
REQ-009 mode_i  in  2  operation: 00 add, 01 subtract, 10 accumulate, 11 load.
REQ-010 a_i  in  CH*W  signed operand A; lane k = bits [k*W +: W].
REQ-011 b_i  in  CH*W  signed operand B, same lane packing.
REQ-012 clr_sat_i  in  1  clears the sticky flags and the event counter.
REQ-013 valid_o  out  1  output beat valid.
REQ-014 ready_i  in  1  downstream accepts the output beat.
REQ-015 result_o  out  CH*W  signed saturated result per lane.
REQ-016 sat_o  out  CH  per-lane flag: the current result_o was clamped.
REQ-017 sat_sticky_o  out  CH  per-lane flag: a clamp occurred since the last clear.
REQ-018 sat_cnt_o  out  CW  count of accepted beats with at least one clamped lane.

Function
REQ-019 An input beat SHALL be accepted when valid_i && ready_o; ready_o = !valid_o || ready_i (one-entry output register, pass-through on a full register).
REQ-020 Latency SHALL be one cycle: an accepted beat appears on result_o/valid_o the next cycle.
REQ-021 valid_o SHALL fall after a handshake with no new input accepted; result_o and sat_o SHALL stay stable while valid_o && !ready_i.
REQ-022 Per-lane arithmetic SHALL use W+1-bit signed intermediates; results above 2^(W-1)-1 clamp to max, and results below -2^(W-1) clamp to min.
REQ-023 Add: r = sat(a+b). Subtract: r = sat(a-b); b = min with a >= 0 SHALL clamp to max.
REQ-024 Accumulate: acc_k <= sat(acc_k + a_k) and r = new acc_k; b_i ignored.
REQ-025 Load: acc_k <= a_k, r = a_k, sat_o = 0; b_i ignored.
REQ-026 Accumulators SHALL update only on an accepted beat; add and subtract leave them unchanged.
REQ-027 sat_o[k] SHALL be registered with result_o and be 1 iff lane k clamped on that beat.
REQ-028 sat_sticky_o[k] SHALL set on any accepted beat where lane k clamps.
REQ-029 sat_cnt_o SHALL increment by 1 per accepted beat with any clamp, holding at 2^CW-1 (no wrap).
REQ-030 clr_sat_i SHALL zero the sticky flags and the counter next cycle; a clamp in the same cycle SHALL win (sticky=1, counter=1).
REQ-031 clr_sat_i SHALL NOT affect accumulators, result_o, sat_o or the handshake.
REQ-032 Lanes SHALL be fully independent; a clamp in one lane SHALL NOT alter another.

Reset
REQ-033 While rst_i=1 at a clock edge, the block SHALL clear valid_o, result_o, sat_o, sat_sticky_o, sat_cnt_o and all accumulators; ready_o SHALL read 1 the following cycle.
REQ-034 Reset asserted mid-stream SHALL discard the in-flight output beat; no beat is accepted in a reset cycle.
REQ-035 Reset SHALL take priority over clr_sat_i and over input handshakes.

Verification (I=4, F=4, W=8, CH=4: max 0x7F, min 0x80)
REQ-036 Add lane0 0x64+0x32, lane1 0x10+0x20 -> lane0 0x7F sat_o[0]=1, lane1 0x30 sat_o[1]=0, sat_cnt_o=1.
REQ-037 Subtract lane0 0x80-0x01, lane1 0x00-0x80 -> 0x80 and 0x7F, both sat_o=1, sticky[1:0]=11.
REQ-038 Load 0x00 then accumulate a=0x3C x3 -> results 0x3C, 0x78, 0x7F(sat); then a=0xC4 -> 0x43.
REQ-039 ready_i=0 for 3 cycles with valid_i held -> result_o stable, exactly one beat accepted, next beat out on the first cycle with ready_i=1.
REQ-040 clr_sat_i in the same cycle as a clamping beat -> sticky=1, sat_cnt_o=1; alone -> both 0; drive 2^CW clamps -> counter holds 0xFFFF.
REQ-041 rst_i during accumulate with valid_o=1 -> next cycle valid_o=0 and all outputs 0; accumulate a=0x05 -> 0x05.
